// File: rtl/led_serializer.sv
// Serial transmitter: latches a byte on load, shifts it out MSB first, then one
// parity bit, each bit held BIT_PERIOD clocks. Mirrors progress on LEDs and a 7-seg digit.
module led_serializer #(
  parameter int BIT_PERIOD = 50_000_000,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       async_nreset,
  input  logic       load_re,
  input  logic       abort_re,
  input  logic [7:0] data_in,
  output logic       serial_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] leds,
  output logic [7:0] hex
);
  localparam int TW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [2:0]      bit_q, bit_d;
  logic            par_q, par_d;
  logic            serial_q, serial_d;
  logic            done_q, done_d;
  logic [7:0]      hex_q, hex_d;
  logic            tick_end;

  assign tick_end = (tick_q == TW'(BIT_PERIOD - 1));

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    par_d   = par_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_re && !abort_re) begin
          shreg_d = data_in;
          par_d   = PARITY_ODD ? ~^data_in : ^data_in;
          tick_d  = '0;
          bit_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (abort_re) begin
          state_d = IDLE;
          shreg_d = '0;
          tick_d  = '0;
          bit_d   = '0;
        end else if (tick_end) begin
          tick_d  = '0;
          shreg_d = {shreg_q[6:0], 1'b0};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = PARITY;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      PARITY: begin
        if (abort_re) begin
          state_d = IDLE;
          shreg_d = '0;
          tick_d  = '0;
          bit_d   = '0;
        end else if (tick_end) begin
          state_d = IDLE;
          tick_d  = '0;
          done_d  = 1'b1;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Serial and 7-seg outputs are registered from next state so they change
  // in the same cycle as the state they describe.
  always_comb begin
    serial_d = 1'b0;
    hex_d    = 8'h00;
    case (state_d)
      SHIFT:   serial_d = shreg_d[7];
      PARITY:  serial_d = par_d;
      default: serial_d = 1'b0;
    endcase
    if (state_d != IDLE)
      hex_d = {state_d == PARITY, serial_d ? 7'b000_0110 : 7'b011_1111};
  end

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      tick_q   <= '0;
      bit_q    <= '0;
      par_q    <= 1'b0;
      serial_q <= 1'b0;
      done_q   <= 1'b0;
      hex_q    <= 8'h00;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      par_q    <= par_d;
      serial_q <= serial_d;
      done_q   <= done_d;
      hex_q    <= hex_d;
    end
  end

  assign serial_out = serial_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign leds       = shreg_q;
  assign hex        = hex_q;
endmodule

// File: tb/tb_led_serializer.sv
// Scoreboard bench for led_serializer: even- and odd-parity instances, BIT_PERIOD=4.
module tb_led_serializer;
  localparam int BP = 4;

  logic clk = 1'b0;
  logic async_nreset = 1'b0;
  logic ld1 = 1'b0, ab1 = 1'b0, ld2 = 1'b0, ab2 = 1'b0;
  logic [7:0] d1 = 8'h00, d2 = 8'h00;
  logic so1, bz1, dn1, so2, bz2, dn2;
  logic [7:0] leds1, hex1, leds2, hex2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  led_serializer #(.BIT_PERIOD(BP), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .async_nreset(async_nreset), .load_re(ld1), .abort_re(ab1),
    .data_in(d1), .serial_out(so1), .busy(bz1), .done(dn1), .leds(leds1), .hex(hex1));

  led_serializer #(.BIT_PERIOD(BP), .PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .async_nreset(async_nreset), .load_re(ld2), .abort_re(ab2),
    .data_in(d2), .serial_out(so2), .busy(bz2), .done(dn2), .leds(leds2), .hex(hex2));

  typedef struct packed {
    logic       s;
    logic       b;
    logic       d;
    logic [7:0] l;
    logic [7:0] h;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h want=%h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs(input bit odd);
    exp_t o;
    if (odd) o = '{so2, bz2, dn2, leds2, hex2};
    else     o = '{so1, bz1, dn1, leds1, hex1};
    return 32'(o);
  endfunction

  task automatic drive(input bit odd, input logic ld, input logic ab, input logic [7:0] d);
    if (odd) begin ld2 = ld; ab2 = ab; d2 = d; end
    else     begin ld1 = ld; ab1 = ab; d1 = d; end
  endtask

  // One transfer: model pushes the expected per-cycle outputs, then each
  // cycle after load is popped and compared. k counts edges after the load edge.
  task automatic xfer(input logic [7:0] d, input bit odd, input int reload_at,
                      input int abort_at, input int rst_at);
    logic par;
    exp_t e;
    int   b;
    par = odd ? ~^d : ^d;
    for (int k = 0; k < 9 * BP; k++) begin
      b = k / BP;
      e = '0;
      e.b = 1'b1;
      if (b < 8) begin
        e.s = d[7-b];
        e.l = d << b;
        e.h = e.s ? 8'h06 : 8'h3F;
      end else begin
        e.s = par;
        e.h = par ? 8'h86 : 8'hBF;
      end
      q.push_back(e);
    end
    e = '0;
    e.d = 1'b1;
    q.push_back(e);

    @(negedge clk);
    drive(odd, 1'b1, 1'b0, d);
    for (int k = 0; k <= 9 * BP; k++) begin
      if (k > 0) begin
        @(negedge clk);
        drive(odd, k == reload_at, k == abort_at, 8'h00);
      end
      @(posedge clk);
      #1;
      if (k == rst_at) begin
        #2 async_nreset = 1'b0;
        #1 chk("async_rst", obs(odd), 32'h0);
        q.delete();
        @(negedge clk);
        async_nreset = 1'b1;
        @(posedge clk);
        #1 chk("post_rst_idle", obs(odd), 32'h0);
        return;
      end
      e = q.pop_front();
      if (k == abort_at) begin
        chk("abort", obs(odd), 32'h0);
        q.delete();
        @(negedge clk);
        drive(odd, 1'b0, 1'b0, 8'h00);
        for (int j = 0; j < 40; j++) begin
          @(posedge clk);
          #1 chk("abort_quiet", obs(odd), 32'h0);
        end
        return;
      end
      chk(odd ? "odd_cycle" : "even_cycle", obs(odd), 32'(e));
    end
  endtask

  initial begin
    #1;
    chk("reset_even", obs(1'b0), 32'h0);
    chk("reset_odd", obs(1'b1), 32'h0);
    repeat (2) @(negedge clk);
    async_nreset = 1'b1;

    // load and abort in the same idle cycle: abort wins
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 8'hA5);
    @(posedge clk);
    #1 chk("ld_ab_idle", obs(1'b0), 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    @(posedge clk);
    #1 chk("ld_ab_idle2", obs(1'b0), 32'h0);

    xfer(8'hA5, 1'b0, -1, -1, -1);
    xfer(8'h5A, 1'b0, -1, -1, -1);   // loaded on the done cycle
    xfer(8'h01, 1'b1, -1, -1, -1);
    xfer(8'h00, 1'b1, -1, -1, -1);
    xfer(8'hFF, 1'b0, 10, -1, -1);   // reload while busy is ignored
    xfer(8'hC3, 1'b0, -1, 13, -1);
    xfer(8'h55, 1'b0, -1, -1, 34);   // reset mid-parity
    xfer(8'h80, 1'b0, -1, -1, -1);

    repeat (3) @(posedge clk);
    #1 chk("final_idle", obs(1'b0), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
